// File: rtl/bht_access_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bht_access_arbiter                                         |
// | Description : Shares one single-port BHT table RAM (2-bit counters,      |
// |               1-cycle read latency) between fetch-side lookups and       |
// |               execute-side counter updates. Updates are buffered in a    |
// |               small FIFO and applied as read-modify-write pairs.         |
// | Macro       : BHT_INIT_EN - when defined, reset enters an INIT sweep     |
// |               that writes 2'b01 to every entry before serving traffic.   |
// | Ports       : clock/reset             - clock, sync active-high reset    |
// |               lookup_valid/index/ready - prediction request handshake    |
// |               pred_valid/pred_taken   - prediction, one cycle later      |
// |               upd_valid/index/taken/ready - resolved-branch push         |
// |               tbl_en/we/addr/wdata/rdata - table RAM port                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module bht_access_arbiter #(
  parameter int INDEX_W = 6,
  parameter int QDEPTH  = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               lookup_valid,
  input  logic [INDEX_W-1:0] lookup_index,
  output logic               lookup_ready,
  output logic               pred_valid,
  output logic               pred_taken,
  input  logic               upd_valid,
  input  logic [INDEX_W-1:0] upd_index,
  input  logic               upd_taken,
  output logic               upd_ready,
  output logic               tbl_en,
  output logic               tbl_we,
  output logic [INDEX_W-1:0] tbl_addr,
  output logic [1:0]         tbl_wdata,
  input  logic [1:0]         tbl_rdata
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

`ifdef BHT_INIT_EN
  localparam logic [1:0] ST_INIT   = 2'd0;
`endif
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_UPD_RD = 2'd2;
  localparam logic [1:0] ST_UPD_WR = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               pred_valid_q, pred_valid_d;
  logic [INDEX_W-1:0] fifo_idx_q [QDEPTH];
  logic               fifo_tkn_q [QDEPTH];

  logic               full, empty, push, pop, in_init;
  logic [INDEX_W-1:0] head_idx;
  logic               head_tkn;
  logic [1:0]         sat_cnt;

`ifdef BHT_INIT_EN
  logic [INDEX_W-1:0] init_addr_q, init_addr_d;
  assign in_init = (state_q == ST_INIT);
`else
  assign in_init = 1'b0;
`endif

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign head_idx = fifo_idx_q[head_q];
  assign head_tkn = fifo_tkn_q[head_q];

  // Saturating 2-bit counter step applied to the value read in UPD_RD.
  always_comb begin
    sat_cnt = tbl_rdata;
    if (head_tkn) begin
      if (tbl_rdata != 2'b11) sat_cnt = tbl_rdata + 2'b01;
    end else begin
      if (tbl_rdata != 2'b00) sat_cnt = tbl_rdata - 2'b01;
    end
  end

  always_comb begin
    state_d      = state_q;
    lookup_ready = 1'b0;
    tbl_en       = 1'b0;
    tbl_we       = 1'b0;
    tbl_addr     = '0;
    tbl_wdata    = 2'b00;
    pop          = 1'b0;
`ifdef BHT_INIT_EN
    init_addr_d  = init_addr_q;
`endif
    case (state_q)
`ifdef BHT_INIT_EN
      ST_INIT: begin
        tbl_en      = 1'b1;
        tbl_we      = 1'b1;
        tbl_addr    = init_addr_q;
        tbl_wdata   = 2'b01;
        init_addr_d = init_addr_q + 1'b1;
        if (init_addr_q == '1) state_d = ST_IDLE;
      end
`endif
      ST_IDLE: begin
        lookup_ready = !full;
        // A full queue pre-empts fetch so execute can never deadlock.
        if (full) begin
          state_d = ST_UPD_RD;
        end else if (lookup_valid) begin
          tbl_en   = 1'b1;
          tbl_addr = lookup_index;
        end else if (!empty) begin
          state_d = ST_UPD_RD;
        end
      end
      ST_UPD_RD: begin
        tbl_en   = 1'b1;
        tbl_addr = head_idx;
        state_d  = ST_UPD_WR;
      end
      ST_UPD_WR: begin
        tbl_en    = 1'b1;
        tbl_we    = 1'b1;
        tbl_addr  = head_idx;
        tbl_wdata = sat_cnt;
        pop       = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Reset abandons any in-flight access: the port is quiet in that cycle.
    if (reset) begin
      lookup_ready = 1'b0;
      tbl_en       = 1'b0;
      tbl_we       = 1'b0;
    end
  end

  // The slot freed by a pop in UPD_WR can be refilled in the same cycle.
  assign upd_ready    = !reset && !in_init && (!full || pop);
  assign push         = upd_valid && upd_ready;
  assign pred_valid_d = lookup_valid && lookup_ready;
  assign pred_valid   = pred_valid_q && !reset;
  assign pred_taken   = pred_valid && tbl_rdata[1];

  assign head_d  = pop  ? head_q + 1'b1 : head_q;
  assign tail_d  = push ? tail_q + 1'b1 : tail_q;
  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clock) begin
    if (reset) begin
`ifdef BHT_INIT_EN
      state_q     <= ST_INIT;
      init_addr_q <= '0;
`else
      state_q     <= ST_IDLE;
`endif
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      pred_valid_q <= 1'b0;
    end else begin
`ifdef BHT_INIT_EN
      init_addr_q <= init_addr_d;
`endif
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      pred_valid_q <= pred_valid_d;
    end
  end

  // Queue storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_idx_q[tail_q] <= upd_index;
      fifo_tkn_q[tail_q] <= upd_taken;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bht_access_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_bht_access_arbiter                                      |
// | Description : Self-checking bench for bht_access_arbiter with a table    |
// |               RAM model and a queue-based reference model.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_bht_access_arbiter;
  localparam int INDEX_W = 6;
  localparam int QDEPTH  = 4;
  localparam int ENTRIES = 1 << INDEX_W;

  logic               clock = 1'b0;
  logic               reset;
  logic               lookup_valid;
  logic [INDEX_W-1:0] lookup_index;
  logic               lookup_ready;
  logic               pred_valid;
  logic               pred_taken;
  logic               upd_valid;
  logic [INDEX_W-1:0] upd_index;
  logic               upd_taken;
  logic               upd_ready;
  logic               tbl_en;
  logic               tbl_we;
  logic [INDEX_W-1:0] tbl_addr;
  logic [1:0]         tbl_wdata;
  logic [1:0]         tbl_rdata;

  bht_access_arbiter #(.INDEX_W(INDEX_W), .QDEPTH(QDEPTH)) dut (
    .clock(clock), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_index(lookup_index), .lookup_ready(lookup_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken), .upd_ready(upd_ready),
    .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .tbl_rdata(tbl_rdata)
  );

  always #5 clock = ~clock;

  // Table RAM with a bench-side preload port.
  logic [1:0]         ram [ENTRIES];
  logic               pl_en;
  logic [INDEX_W-1:0] pl_addr;
  logic [1:0]         pl_data;
  always @(posedge clock) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (tbl_en) begin
      if (tbl_we) ram[tbl_addr] <= tbl_wdata;
      else        tbl_rdata     <= ram[tbl_addr];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: pending updates as a queue, busy = remaining drain cycles.
  typedef struct packed {
    logic [INDEX_W-1:0] idx;
    logic               tkn;
  } upd_t;
  upd_t       q[$];
  int         busy;
  int         init_left;
  bit         pred_pending;
  bit         pred_bit;
  logic [1:0] ref_tbl [ENTRIES];

  logic s_lr, s_ur, s_pv, s_pt, s_en, s_we;
  logic [INDEX_W-1:0] s_addr;
  logic [1:0] s_wd;

  function automatic logic [1:0] bump(input logic [1:0] c, input logic t);
    int v;
    v = int'(c) + (t ? 1 : -1);
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return 2'(v);
  endfunction

  // One clock cycle: inputs already set; sample mid-cycle, check, advance.
  task automatic step();
    bit   full, lookup, push;
    int   had;
    upd_t h;
    logic [1:0] nv;
    #4;
    s_lr = lookup_ready; s_ur = upd_ready; s_pv = pred_valid; s_pt = pred_taken;
    s_en = tbl_en; s_we = tbl_we; s_addr = tbl_addr; s_wd = tbl_wdata;
    if (reset) begin
      chk("rst_lookup_ready", s_lr, 0);
      chk("rst_upd_ready", s_ur, 0);
      chk("rst_pred_valid", s_pv, 0);
      chk("rst_tbl_en", s_en, 0);
      q.delete();
      busy = 0;
      pred_pending = 0;
`ifdef BHT_INIT_EN
      init_left = ENTRIES;
`endif
    end else begin
      chk("pred_valid", s_pv, pred_pending);
      if (pred_pending) chk("pred_taken", s_pt, pred_bit);
      pred_pending = 0;
      if (init_left > 0) begin
        chk("init_lookup_ready", s_lr, 0);
        chk("init_upd_ready", s_ur, 0);
        chk("init_tbl_en", s_en, 1);
        chk("init_tbl_we", s_we, 1);
        chk("init_tbl_addr", s_addr, ENTRIES - init_left);
        chk("init_tbl_wdata", s_wd, 1);
        ref_tbl[ENTRIES - init_left] = 2'b01;
        init_left--;
      end else begin
        full   = (q.size() >= QDEPTH);
        had    = q.size();
        lookup = lookup_valid && busy == 0 && !full;
        push   = upd_valid && (!full || busy == 1);
        chk("lookup_ready", s_lr, (busy == 0 && !full));
        chk("upd_ready", s_ur, (!full || busy == 1));
        if (busy == 2) begin
          chk("rd_tbl_en", s_en, 1);
          chk("rd_tbl_we", s_we, 0);
          chk("rd_tbl_addr", s_addr, q[0].idx);
          busy = 1;
        end else if (busy == 1) begin
          h  = q.pop_front();
          nv = bump(ref_tbl[h.idx], h.tkn);
          chk("wr_tbl_en", s_en, 1);
          chk("wr_tbl_we", s_we, 1);
          chk("wr_tbl_addr", s_addr, h.idx);
          chk("wr_tbl_wdata", s_wd, nv);
          ref_tbl[h.idx] = nv;
          busy = 0;
        end else begin
          chk("idle_tbl_en", s_en, lookup);
          if (lookup) begin
            chk("lk_tbl_we", s_we, 0);
            chk("lk_tbl_addr", s_addr, lookup_index);
            pred_pending = 1;
            pred_bit     = ref_tbl[lookup_index][1];
          end
          if (full || (!lookup_valid && had > 0)) busy = 2;
        end
        if (push) q.push_back('{idx: upd_index, tkn: upd_taken});
      end
    end
    if (pl_en) ref_tbl[pl_addr] = pl_data;
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    lookup_valid = 0; lookup_index = '0;
    upd_valid = 0; upd_index = '0; upd_taken = 0;
  endtask

  typedef struct {
    bit lv; logic [INDEX_W-1:0] li; bit uv; logic [INDEX_W-1:0] ui; bit ut;
    bit lr; bit ur; bit pv; bit pt; bit en; bit we; logic [INDEX_W-1:0] addr; logic [1:0] wd;
  } vec_t;
  vec_t vt[15];

  initial begin
    vt[0]  = '{1, 5, 0, 0, 0,  1, 1, 0, 0, 1, 0, 5, 0};
    vt[1]  = '{0, 0, 1, 7, 1,  1, 1, 1, 1, 0, 0, 0, 0};
    vt[2]  = '{0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0};
    vt[3]  = '{0, 0, 0, 0, 0,  0, 1, 0, 0, 1, 0, 7, 0};
    vt[4]  = '{0, 0, 0, 0, 0,  0, 1, 0, 0, 1, 1, 7, 3};
    vt[5]  = '{1, 5, 1, 8, 0,  1, 1, 0, 0, 1, 0, 5, 0};
    vt[6]  = '{1, 7, 0, 0, 0,  1, 1, 1, 1, 1, 0, 7, 0};
    vt[7]  = '{0, 0, 0, 0, 0,  1, 1, 1, 1, 0, 0, 0, 0};
    vt[8]  = '{0, 0, 1, 9, 1,  0, 1, 0, 0, 1, 0, 8, 0};
    vt[9]  = '{0, 0, 0, 0, 0,  0, 1, 0, 0, 1, 1, 8, 0};
    vt[10] = '{0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0};
    vt[11] = '{0, 0, 0, 0, 0,  0, 1, 0, 0, 1, 0, 9, 0};
    vt[12] = '{0, 0, 0, 0, 0,  0, 1, 0, 0, 1, 1, 9, 2};
    vt[13] = '{1, 9, 0, 0, 0,  1, 1, 0, 0, 1, 0, 9, 0};
    vt[14] = '{0, 0, 0, 0, 0,  1, 1, 1, 1, 0, 0, 0, 0};

    busy = 0; init_left = 0; pred_pending = 0; pred_bit = 0;
    reset = 1; pl_en = 0; pl_addr = '0; pl_data = '0;
    quiet();
    @(posedge clock); #1;
    step(); step();
    reset = 0;
`ifdef BHT_INIT_EN
    for (int i = 0; i < ENTRIES; i++) step();
`endif
    step();
    chk("post_reset_lookup_ready", s_lr, 1);
    chk("post_reset_upd_ready", s_ur, 1);

    // Preload known counters while the arbiter is idle.
    for (int i = 0; i < ENTRIES; i++) begin
      pl_en = 1; pl_addr = INDEX_W'(i);
      case (i)
        5: pl_data = 2'b10;
        7: pl_data = 2'b11;
        8: pl_data = 2'b00;
        9: pl_data = 2'b01;
        default: pl_data = 2'($urandom_range(0, 3));
      endcase
      step();
    end
    pl_en = 0;

    // Directed vectors: lookup latency, saturation, arbitration.
    for (int i = 0; i < 15; i++) begin
      lookup_valid = vt[i].lv; lookup_index = vt[i].li;
      upd_valid = vt[i].uv; upd_index = vt[i].ui; upd_taken = vt[i].ut;
      step();
      chk($sformatf("v%0d_lookup_ready", i), s_lr, vt[i].lr);
      chk($sformatf("v%0d_upd_ready", i), s_ur, vt[i].ur);
      chk($sformatf("v%0d_pred_valid", i), s_pv, vt[i].pv);
      if (vt[i].pv) chk($sformatf("v%0d_pred_taken", i), s_pt, vt[i].pt);
      chk($sformatf("v%0d_tbl_en", i), s_en, vt[i].en);
      if (vt[i].en) begin
        chk($sformatf("v%0d_tbl_we", i), s_we, vt[i].we);
        chk($sformatf("v%0d_tbl_addr", i), s_addr, vt[i].addr);
        if (vt[i].we) chk($sformatf("v%0d_tbl_wdata", i), s_wd, vt[i].wd);
      end
    end
    quiet();
    step();

    // Full queue while fetch keeps asking; push/pop overlap in UPD_WR.
    lookup_valid = 1; lookup_index = 6'd3; upd_valid = 1;
    for (int k = 0; k < 4; k++) begin
      upd_index = INDEX_W'(10 + k); upd_taken = k[0];
      step();
    end
    upd_index = 6'd14;
    step();
    chk("full_upd_ready", s_ur, 0);
    chk("full_lookup_ready", s_lr, 0);
    step();
    chk("full_rd_en", s_en, 1);
    chk("full_rd_we", s_we, 0);
    chk("full_rd_addr", s_addr, 10);
    step();
    chk("full_wr_upd_ready", s_ur, 1);
    chk("full_wr_we", s_we, 1);
    upd_valid = 0;
    step();
    chk("still_full_upd_ready", s_ur, 0);
    chk("still_full_lookup_ready", s_lr, 0);
    quiet();
    for (int k = 0; k < 12; k++) step();
    chk("drained_lookup_ready", s_lr, 1);

    // Reset while in UPD_RD with three queued updates.
    lookup_valid = 1; lookup_index = 6'd2;
    upd_valid = 1; upd_index = 6'd20; upd_taken = 1; step();
    upd_index = 6'd21; step();
    lookup_valid = 0; upd_index = 6'd22; step();
    upd_valid = 0; reset = 1;
    step();
    chk("rst_in_rd_tbl_en", s_en, 0);
    reset = 0;
`ifdef BHT_INIT_EN
    step();
    chk("rst_init_upd_ready", s_ur, 0);
    for (int i = 1; i < ENTRIES; i++) step();
`endif
    for (int k = 0; k < 4; k++) begin
      step();
      chk("flushed_no_access", s_en, 0);
      chk("flushed_upd_ready", s_ur, 1);
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      reset        = ($urandom_range(0, 299) == 0);
      lookup_valid = 1'($urandom_range(0, 1));
      lookup_index = INDEX_W'($urandom_range(0, 15));
      upd_valid    = ($urandom_range(0, 2) != 0);
      upd_index    = INDEX_W'($urandom_range(0, 15));
      upd_taken    = 1'($urandom_range(0, 1));
      step();
    end
    reset = 0;
    quiet();
    for (int k = 0; k < 80; k++) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
